// File: rtl/rr_arb_enc4_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter
// that drives the 2-to-4 grant decoder.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_arb_enc4_next_idx.sv
// Combinational round-robin pick: the first set request after i_ptr, searched
// cyclically, so i_ptr itself is the lowest-priority candidate.
module rr_next_idx
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  idx_t            i_ptr,
    output logic            o_found,
    output idx_t            o_idx
);

    idx_t w_cand;

    // Walk from the farthest candidate to the nearest so the nearest hit is the one that sticks.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_cand = i_ptr + idx_t'(i);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_enc4.sv
// Round-robin arbiter for 4 requesters with hold timeout; the registered
// grant index feeds the decoder select lines and is qualified by o_gnt_vld.
module rr_arb_enc4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_done,
    output logic            o_gnt_vld,
    output idx_t            o_gnt_idx,
    output logic            o_timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam idx_t             PTR_RST   = idx_t'(NREQ - 1);

    arb_state_t       r_state;
    logic             r_gnt_vld;
    idx_t             r_gnt_idx;
    idx_t             r_last_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    arb_state_t       w_state_nxt;
    logic             w_vld_nxt;
    idx_t             w_idx_nxt;
    idx_t             w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_to_nxt;

    idx_t             w_ptr;
    logic             w_found;
    idx_t             w_pick;
    logic             w_owner_req;
    logic             w_hold_exp;
    logic             w_release;

    // While granted, the current owner is the rotation point, so it re-enters last.
    assign w_ptr       = (r_state == GRANT) ? r_gnt_idx : r_last_ptr;
    assign w_owner_req = i_req[r_gnt_idx];
    assign w_hold_exp  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_release   = i_done | ~w_owner_req | w_hold_exp;

    rr_next_idx u_next_idx (
        .i_req   (i_req),
        .i_ptr   (w_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_vld_nxt   = r_gnt_vld;
        w_idx_nxt   = r_gnt_idx;
        w_last_nxt  = r_last_ptr;
        w_cnt_nxt   = r_hold_cnt;
        w_to_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_vld_nxt   = 1'b1;
                    w_idx_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_last_nxt = r_gnt_idx;
                    // Only a purely counter-driven release is reported as a timeout.
                    w_to_nxt   = w_hold_exp & ~i_done & w_owner_req;
                    if (w_found) begin
                        w_idx_nxt = w_pick;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_vld_nxt   = 1'b0;
                    end
                end else if (r_hold_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_gnt_vld  <= 1'b0;
            r_gnt_idx  <= '0;
            r_last_ptr <= PTR_RST;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_vld  <= w_vld_nxt;
            r_gnt_idx  <= w_idx_nxt;
            r_last_ptr <= w_last_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_timeout  <= w_to_nxt;
        end
    end

    assign o_gnt_vld = r_gnt_vld;
    assign o_gnt_idx = r_gnt_idx;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_arb_enc4.sv
// Bench for rr_arb_enc4 (MAX_HOLD=8): directed vectors with literal checks,
// plus a per-cycle comparison against a grant-length-based reference model.
module tb_rr_arb_enc4;

    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic       gntVld;
    logic [1:0] gntIdx;
    logic       timeoutP;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    rr_arb_enc4 #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_done    (done),
        .o_gnt_vld (gntVld),
        .o_gnt_idx (gntIdx),
        .o_timeout (timeoutP)
    );

    always #5 clk = ~clk;

    // Reference model: tracks how many cycles the current owner has held the grant.
    typedef struct {
        bit vld;
        int idx;
        int last;
        int held;
        bit to;
    } mState_t;

    mState_t m = '{vld: 1'b0, idx: 0, last: 3, held: 0, to: 1'b0};

    function automatic int pickM(logic [3:0] r, int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic mState_t modelNext(mState_t s, logic [3:0] r, logic d);
        mState_t n;
        bit ctr;
        n    = s;
        n.to = 1'b0;
        if (!s.vld) begin
            if (r != 4'b0000) begin
                n.vld  = 1'b1;
                n.idx  = pickM(r, s.last);
                n.held = 1;
            end
        end else begin
            ctr = (MAXH != 0) && (s.held == MAXH);
            if (d || !r[s.idx] || ctr) begin
                n.to   = ctr && !d && r[s.idx];
                n.last = s.idx;
                if (r != 4'b0000) begin
                    n.idx  = pickM(r, s.idx);
                    n.held = 1;
                end else begin
                    n.vld = 1'b0;
                end
            end else begin
                n.held = s.held + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{vld: 1'b0, idx: 0, last: 3, held: 0, to: 1'b0};
        else     m <= modelNext(m, req, done);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_vld", int'(gntVld), int'(m.vld));
            checkOutput("model_timeout", int'(timeoutP), int'(m.to));
            if (m.vld) checkOutput("model_idx", int'(gntIdx), m.idx);
        end
    end

    task automatic applyStimulus(input logic [3:0] r, input logic d);
        @(posedge clk);
        #2;
        req  = r;
        done = d;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Reset held with every requester asserting.
        #1;
        rst     = 1'b1;
        req     = 4'b1111;
        checkEn = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("rst_vld", int'(gntVld), 0);
        checkOutput("rst_idx", int'(gntIdx), 0);
        releaseReset();
        applyStimulus(4'b1111, 1'b0);
        checkOutput("first_vld", int'(gntVld), 1);
        checkOutput("first_idx", int'(gntIdx), 0);

        // Done every third cycle rotates 0,1,2,3,0 with no bubble.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111, 1'b0);
            applyStimulus(4'b1111, 1'b1);
            applyStimulus(4'b1111, 1'b0);
            checkOutput("rot_vld", int'(gntVld), 1);
            checkOutput("rot_idx", int'(gntIdx), (k + 1) % 4);
        end

        // Single requester 2, then drop it.
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("idle_vld", int'(gntVld), 0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("solo_vld", int'(gntVld), 1);
        checkOutput("solo_idx", int'(gntIdx), 2);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("drop_vld", int'(gntVld), 0);

        // Sole requester 0 held with no done: timeout every MAXH cycles.
        applyStimulus(4'b0001, 1'b0);
        for (int n = 1; n <= 24; n++) begin
            applyStimulus(4'b0001, 1'b0);
            checkOutput("hold_vld", int'(gntVld), 1);
            checkOutput("hold_idx", int'(gntIdx), 0);
            checkOutput("hold_timeout", int'(timeoutP), (n == 9 || n == 17) ? 1 : 0);
        end

        // Move grant to 3, then reset between edges.
        applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("pre_rst_idx", int'(gntIdx), 3);
        checkOutput("pre_rst_vld", int'(gntVld), 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_vld", int'(gntVld), 0);
        applyStimulus(4'b1001, 1'b0);
        releaseReset();
        applyStimulus(4'b1001, 1'b0);
        checkOutput("post_rst_vld", int'(gntVld), 1);
        checkOutput("post_rst_idx", int'(gntIdx), 0);

        // done while idle is ignored.
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("idle_done_vld", int'(gntVld), 0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("idle_done_vld2", int'(gntVld), 0);
        checkOutput("idle_done_to", int'(timeoutP), 0);

        // done coincides with the hold expiry: no timeout pulse.
        applyStimulus(4'b0001, 1'b0);
        for (int k = 1; k <= 7; k++) applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("done_to_timeout", int'(timeoutP), 0);
        checkOutput("done_to_vld", int'(gntVld), 1);
        checkOutput("done_to_idx", int'(gntIdx), 0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("done_to_timeout2", int'(timeoutP), 0);

        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
